// File: rtl/scv_cart_ctl_if.sv
// Bus bundle for scv_cart_ctl: CPU cart-window strobes, ROM download strobe and the
// single-port cart memory request/acknowledge channel.
interface scv_cart_ctl_if #(
   parameter int AW = 17
);
   logic [15:0]   CPU_A;
   logic          CART_NCS;
   logic          CPU_RDB;
   logic          CPU_WRB;
   logic [7:0]    CPU_DB_I;
   logic [7:0]    CPU_DB_O;
   logic          CPU_DB_OE;
   logic [AW-1:0] LD_ADDR;
   logic [7:0]    LD_DATA;
   logic          LD_VALID;
   logic          LD_OVF;
   logic          BUSY;
   logic [AW-1:0] MEM_A;
   logic [7:0]    MEM_DO;
   logic          MEM_WE;
   logic          MEM_REQ;
   logic          MEM_ACK;
   logic [7:0]    MEM_DI;

   // Memory channel: MEM_REQ rises with MEM_A/MEM_DO/MEM_WE valid and holds them
   // stable until the cycle MEM_ACK=1 is sampled; read data is valid in that cycle.
   // REQ may drop without ACK only on reset. LD_VALID has no back-pressure.
   modport slave (
      input  CPU_A, CART_NCS, CPU_RDB, CPU_WRB, CPU_DB_I,
      input  LD_ADDR, LD_DATA, LD_VALID, MEM_ACK, MEM_DI,
      output CPU_DB_O, CPU_DB_OE, LD_OVF, BUSY, MEM_A, MEM_DO, MEM_WE, MEM_REQ
   );

   modport master (
      output CPU_A, CART_NCS, CPU_RDB, CPU_WRB, CPU_DB_I,
      output LD_ADDR, LD_DATA, LD_VALID, MEM_ACK, MEM_DI,
      input  CPU_DB_O, CPU_DB_OE, LD_OVF, BUSY, MEM_A, MEM_DO, MEM_WE, MEM_REQ
   );
endinterface

// File: rtl/scv_cart_ctl.sv
// Cart memory arbiter: CPU cart accesses take priority over buffered ROM download writes.
// Define SCV_CART_RAM_EN to allow CPU writes at/above RAM_BASE; otherwise the cart is ROM-only.
module scv_cart_ctl #(
   parameter int          AW         = 17,
   parameter int          FIFO_DEPTH = 4,
   parameter logic [15:0] RAM_BASE   = 16'hE000
) (
   input  logic              CLK,
   input  logic              RESB,
   scv_cart_ctl_if.slave     bus,
   output logic [1:0]        dbg_state
);
   localparam int PW = $clog2(FIFO_DEPTH);
   localparam logic [PW:0] PTR_ONE = {{PW{1'b0}}, 1'b1};
`ifdef SCV_CART_RAM_EN
   localparam bit RAM_EN = 1'b1;
`else
   localparam bit RAM_EN = 1'b0;
`endif

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      CPU_RD = 2'd1,
      CPU_WR = 2'd2,
      LD_WR  = 2'd3
   } state_t;

   state_t        state, state_nxt;
   logic          rd_act, wr_act, rd_act_q, wr_act_q;
   logic          rd_pend, wr_pend;
   logic          take_rd, take_wr, take_ld, drop_wr;
   logic          wr_ok;
   logic [AW-1:0] cpu_addr;
   logic [AW-1:0] mem_a;
   logic [7:0]    mem_do;
   logic          mem_we;
   logic [7:0]    rd_data;
   logic          data_valid;
   logic [7:0]    fifo_data [FIFO_DEPTH];
   logic [AW-1:0] fifo_addr [FIFO_DEPTH];
   logic [PW:0]   wp, rp;
   logic          fifo_empty, fifo_full, push, pop;
   logic          ld_ovf;

   assign rd_act   = ~bus.CART_NCS & ~bus.CPU_RDB;
   assign wr_act   = ~bus.CART_NCS & ~bus.CPU_WRB;
   assign cpu_addr = {{(AW-15){1'b0}}, bus.CPU_A[14:0]};
   assign wr_ok    = RAM_EN && (bus.CPU_A >= RAM_BASE);

   // Extra pointer bit tells full (MSBs differ) from empty (pointers equal).
   assign fifo_empty = (wp == rp);
   assign fifo_full  = (wp[PW] != rp[PW]) && (wp[PW-1:0] == rp[PW-1:0]);
   assign pop        = (state == LD_WR) && bus.MEM_ACK;
   assign push       = bus.LD_VALID && (!fifo_full || pop);

   always_comb begin
      state_nxt = state;
      take_rd   = 1'b0;
      take_wr   = 1'b0;
      take_ld   = 1'b0;
      drop_wr   = 1'b0;
      case (state)
         IDLE: begin
            if (rd_pend) begin
               take_rd   = 1'b1;
               state_nxt = CPU_RD;
            end else if (wr_pend && wr_ok) begin
               take_wr   = 1'b1;
               state_nxt = CPU_WR;
            end else begin
               // A write that cannot reach memory is retired here without a memory op.
               drop_wr = wr_pend;
               if (!fifo_empty) begin
                  take_ld   = 1'b1;
                  state_nxt = LD_WR;
               end
            end
         end
         default: begin
            if (bus.MEM_ACK) state_nxt = IDLE;
         end
      endcase
   end

   always_ff @(posedge CLK or negedge RESB) begin
      if (!RESB) begin
         state    <= IDLE;
         rd_act_q <= 1'b0;
         wr_act_q <= 1'b0;
         rd_pend  <= 1'b0;
         wr_pend  <= 1'b0;
      end else begin
         state    <= state_nxt;
         rd_act_q <= rd_act;
         wr_act_q <= wr_act;
         if (rd_act && !rd_act_q) rd_pend <= 1'b1;
         else if (take_rd)        rd_pend <= 1'b0;
         if (wr_act && !wr_act_q)      wr_pend <= 1'b1;
         else if (take_wr || drop_wr)  wr_pend <= 1'b0;
      end
   end

   // Request fields are captured on leaving IDLE so they stay stable until ACK.
   always_ff @(posedge CLK or negedge RESB) begin
      if (!RESB) begin
         mem_a  <= '0;
         mem_do <= 8'h00;
         mem_we <= 1'b0;
      end else if (take_rd) begin
         mem_a  <= cpu_addr;
         mem_we <= 1'b0;
      end else if (take_wr) begin
         mem_a  <= cpu_addr;
         mem_do <= bus.CPU_DB_I;
         mem_we <= 1'b1;
      end else if (take_ld) begin
         mem_a  <= fifo_addr[rp[PW-1:0]];
         mem_do <= fifo_data[rp[PW-1:0]];
         mem_we <= 1'b1;
      end
   end

   // Read data is discarded if the CPU strobe has already gone away at ACK.
   always_ff @(posedge CLK or negedge RESB) begin
      if (!RESB) begin
         rd_data    <= 8'hFF;
         data_valid <= 1'b0;
      end else begin
         if ((state == CPU_RD) && bus.MEM_ACK) rd_data <= bus.MEM_DI;
         if (!rd_act)                                data_valid <= 1'b0;
         else if ((state == CPU_RD) && bus.MEM_ACK)  data_valid <= 1'b1;
      end
   end

   always_ff @(posedge CLK or negedge RESB) begin
      if (!RESB) begin
         wp     <= '0;
         rp     <= '0;
         ld_ovf <= 1'b0;
      end else begin
         if (push) wp <= wp + PTR_ONE;
         if (pop)  rp <= rp + PTR_ONE;
         if (bus.LD_VALID && !push) ld_ovf <= 1'b1;
      end
   end

   always_ff @(posedge CLK) begin
      if (push) begin
         fifo_data[wp[PW-1:0]] <= bus.LD_DATA;
         fifo_addr[wp[PW-1:0]] <= bus.LD_ADDR;
      end
   end

   assign bus.MEM_REQ   = (state != IDLE);
   assign bus.MEM_A     = mem_a;
   assign bus.MEM_DO    = mem_do;
   assign bus.MEM_WE    = mem_we;
   assign bus.CPU_DB_OE = rd_act;
   assign bus.CPU_DB_O  = data_valid ? rd_data : 8'hFF;
   assign bus.LD_OVF    = ld_ovf;
   assign bus.BUSY      = !fifo_empty || (state != IDLE);
   assign dbg_state     = state;
endmodule

// File: tb/tb_scv_cart_ctl.sv
// Directed bench for scv_cart_ctl with a behavioural variable-latency memory and an
// expected-operation queue compared against the memory's operation log.
module tb_scv_cart_ctl;
   localparam int AW = 17;

   logic       clk = 1'b0;
   logic       resb = 1'b0;
   logic [1:0] dbg_state;
   int         n_pass = 0;
   int         n_total = 0;

   scv_cart_ctl_if #(.AW(AW)) bus ();

   scv_cart_ctl #(.AW(AW), .FIFO_DEPTH(4), .RAM_BASE(16'hE000)) dut (
      .CLK       (clk),
      .RESB      (resb),
      .bus       (bus),
      .dbg_state (dbg_state)
   );

   always #5 clk = ~clk;

   // memory model state
   logic [7:0]  mem_arr [256];
   int          ack_lat = 1;
   bit          mem_hold = 1'b0;
   int          req_cnt = 0;
   logic [25:0] op_log[$];
   logic [25:0] exp_q[$];

   // bus monitor state
   int            req_rises = 0;
   int            stab_viol = 0;
   int            gap_viol = 0;
   bit            cpu_wr_seen = 1'b0;
   logic          prev_req = 1'b0;
   logic          prev_ack = 1'b0;
   logic [AW-1:0] prev_a;
   logic [7:0]    prev_do;
   logic          prev_we;

   initial begin
      bus.MEM_ACK = 1'b0;
      bus.MEM_DI  = 8'h00;
      forever begin
         @(posedge clk); #1;
         if (bus.MEM_REQ && !bus.MEM_ACK && !mem_hold) begin
            req_cnt++;
            if (req_cnt >= ack_lat) begin
               bus.MEM_ACK = 1'b1;
               if (bus.MEM_WE) mem_arr[bus.MEM_A[7:0]] = bus.MEM_DO;
               bus.MEM_DI = mem_arr[bus.MEM_A[7:0]];
               op_log.push_back({bus.MEM_WE, bus.MEM_A, bus.MEM_WE ? bus.MEM_DO : bus.MEM_DI});
            end
         end else if (!bus.MEM_REQ || bus.MEM_ACK) begin
            bus.MEM_ACK = 1'b0;
            req_cnt = 0;
         end
      end
   end

   always @(negedge clk) begin
      if (bus.MEM_REQ && !prev_req) req_rises++;
      if (bus.MEM_REQ && prev_req && prev_ack) gap_viol++;
      if (bus.MEM_REQ && prev_req && !prev_ack &&
          ((bus.MEM_A !== prev_a) || (bus.MEM_DO !== prev_do) || (bus.MEM_WE !== prev_we)))
         stab_viol++;
      if (dbg_state == 2'd2) cpu_wr_seen = 1'b1;
      prev_req = bus.MEM_REQ;
      prev_ack = bus.MEM_ACK;
      prev_a   = bus.MEM_A;
      prev_do  = bus.MEM_DO;
      prev_we  = bus.MEM_WE;
   end

   task automatic test_reset();
      repeat (2) @(negedge clk);
      n_total++;
      if ({bus.MEM_REQ, bus.MEM_WE, bus.MEM_A, bus.MEM_DO} !== {1'b0, 1'b0, 17'h0, 8'h00})
         $display("FAIL rst_mem: got req=%b we=%b a=%h do=%h want 0/0/0/0",
                  bus.MEM_REQ, bus.MEM_WE, bus.MEM_A, bus.MEM_DO);
      else n_pass++;
      n_total++;
      if ({bus.CPU_DB_O, bus.CPU_DB_OE} !== {8'hFF, 1'b0})
         $display("FAIL rst_cpu: got db_o=%h oe=%b want ff/0", bus.CPU_DB_O, bus.CPU_DB_OE);
      else n_pass++;
      n_total++;
      if ({bus.LD_OVF, bus.BUSY, dbg_state} !== 4'b0000)
         $display("FAIL rst_misc: got ovf=%b busy=%b state=%0d want 0/0/0",
                  bus.LD_OVF, bus.BUSY, dbg_state);
      else n_pass++;
      @(posedge clk); #1 resb = 1'b1;
   endtask

   task automatic test_cpu_read();
      int n;
      op_log.delete(); exp_q.delete();
      mem_arr[0] = 8'h5A;
      ack_lat = 3;
      exp_q.push_back({1'b0, 17'h00000, 8'h5A});
      @(posedge clk); #1;
      bus.CPU_A = 16'h8000; bus.CART_NCS = 1'b0; bus.CPU_RDB = 1'b0;
      n = 0;
      do begin
         @(posedge clk); n++;
         @(negedge clk);
      end while (!bus.MEM_REQ && n < 10);
      n_total++;
      if (n != 2) $display("FAIL rd_req_latency: got %0d cycles want 2", n);
      else n_pass++;
      n_total++;
      if ({bus.MEM_WE, bus.MEM_A} !== {1'b0, 17'h0})
         $display("FAIL rd_req_fields: got we=%b a=%h want 0/00000", bus.MEM_WE, bus.MEM_A);
      else n_pass++;
      n = 0;
      while (!bus.MEM_ACK && n < 10) begin @(negedge clk); n++; end
      n_total++;
      if (n >= 10) $display("FAIL rd_ack_timeout: no ACK within %0d cycles", n);
      else n_pass++;
      n_total++;
      if (bus.CPU_DB_O !== 8'hFF) $display("FAIL rd_early_data: got %h want ff", bus.CPU_DB_O);
      else n_pass++;
      @(negedge clk);
      n_total++;
      if ({bus.CPU_DB_O, bus.CPU_DB_OE} !== {8'h5A, 1'b1})
         $display("FAIL rd_data: got db_o=%h oe=%b want 5a/1", bus.CPU_DB_O, bus.CPU_DB_OE);
      else n_pass++;
      repeat (8) @(posedge clk);
      #1 bus.CART_NCS = 1'b1; bus.CPU_RDB = 1'b1;
      repeat (2) @(negedge clk);
      n_total++;
      if ({bus.CPU_DB_O, bus.CPU_DB_OE} !== {8'hFF, 1'b0})
         $display("FAIL rd_end: got db_o=%h oe=%b want ff/0", bus.CPU_DB_O, bus.CPU_DB_OE);
      else n_pass++;
      n_total++;
      if (op_log.size() != exp_q.size())
         $display("FAIL rd_ops: got %0d ops want %0d", op_log.size(), exp_q.size());
      else n_pass++;
      for (int i = 0; i < exp_q.size() && i < op_log.size(); i++) begin
         n_total++;
         if (op_log[i] !== exp_q[i]) $display("FAIL rd_op%0d: got %h want %h", i, op_log[i], exp_q[i]);
         else n_pass++;
      end
   endtask

   task automatic test_ld_writes();
      int n;
      op_log.delete(); exp_q.delete();
      ack_lat = 1;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         bus.LD_VALID = 1'b1;
         bus.LD_ADDR  = AW'(i);
         bus.LD_DATA  = 8'(8'h11 * (i + 1));
         exp_q.push_back({1'b1, 17'(i), 8'(8'h11 * (i + 1))});
      end
      @(posedge clk); #1 bus.LD_VALID = 1'b0;
      @(negedge clk);
      n_total++;
      if (bus.BUSY !== 1'b1) $display("FAIL ld_busy_high: got %b want 1", bus.BUSY);
      else n_pass++;
      n = 0;
      while (bus.BUSY && n < 40) begin @(negedge clk); n++; end
      n_total++;
      if (n >= 40) $display("FAIL ld_busy_timeout: BUSY still %b after %0d cycles", bus.BUSY, n);
      else n_pass++;
      n_total++;
      if (op_log.size() != exp_q.size())
         $display("FAIL ld_ops: got %0d ops want %0d", op_log.size(), exp_q.size());
      else n_pass++;
      for (int i = 0; i < exp_q.size() && i < op_log.size(); i++) begin
         n_total++;
         if (op_log[i] !== exp_q[i]) $display("FAIL ld_op%0d: got %h want %h", i, op_log[i], exp_q[i]);
         else n_pass++;
      end
      n_total++;
      if ({gap_viol, stab_viol} != {32'd0, 32'd0})
         $display("FAIL ld_protocol: got gap=%0d stab=%0d want 0/0", gap_viol, stab_viol);
      else n_pass++;
   endtask

   task automatic test_overflow();
      int n;
      op_log.delete(); exp_q.delete();
      mem_hold = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         bus.LD_VALID = 1'b1;
         bus.LD_ADDR  = AW'(16 + i);
         bus.LD_DATA  = 8'(8'hA0 + i);
         if (i < 4) exp_q.push_back({1'b1, 17'(16 + i), 8'(8'hA0 + i)});
      end
      @(negedge clk);
      n_total++;
      if (bus.LD_OVF !== 1'b0) $display("FAIL ovf_early: got %b want 0", bus.LD_OVF);
      else n_pass++;
      @(posedge clk); #1 bus.LD_VALID = 1'b0;
      @(negedge clk);
      n_total++;
      if (bus.LD_OVF !== 1'b1) $display("FAIL ovf_set: got %b want 1", bus.LD_OVF);
      else n_pass++;
      mem_hold = 1'b0;
      n = 0;
      while (bus.BUSY && n < 60) begin @(negedge clk); n++; end
      n_total++;
      if (n >= 60) $display("FAIL ovf_drain_timeout: BUSY still %b", bus.BUSY);
      else n_pass++;
      n_total++;
      if (op_log.size() != exp_q.size())
         $display("FAIL ovf_ops: got %0d ops want %0d", op_log.size(), exp_q.size());
      else n_pass++;
      for (int i = 0; i < exp_q.size() && i < op_log.size(); i++) begin
         n_total++;
         if (op_log[i] !== exp_q[i]) $display("FAIL ovf_op%0d: got %h want %h", i, op_log[i], exp_q[i]);
         else n_pass++;
      end
      n_total++;
      if (bus.LD_OVF !== 1'b1) $display("FAIL ovf_sticky: got %b want 1", bus.LD_OVF);
      else n_pass++;
   endtask

   task automatic test_read_during_ld();
      int n;
      op_log.delete(); exp_q.delete();
      ack_lat = 4;
      mem_arr[5] = 8'hC3;
      exp_q.push_back({1'b1, 17'h00020, 8'h77});
      exp_q.push_back({1'b0, 17'h00005, 8'hC3});
      @(posedge clk); #1;
      bus.LD_VALID = 1'b1; bus.LD_ADDR = AW'(32); bus.LD_DATA = 8'h77;
      @(posedge clk); #1 bus.LD_VALID = 1'b0;
      n = 0;
      while (!(bus.MEM_REQ && bus.MEM_WE) && n < 10) begin @(negedge clk); n++; end
      n_total++;
      if (n >= 10) $display("FAIL rdl_ld_timeout: load write not issued within %0d cycles", n);
      else n_pass++;
      @(posedge clk); #1;
      bus.CPU_A = 16'h8005; bus.CART_NCS = 1'b0; bus.CPU_RDB = 1'b0;
      repeat (13) @(posedge clk);
      @(negedge clk);
      n_total++;
      if ({bus.CPU_DB_O, bus.CPU_DB_OE} !== {8'hC3, 1'b1})
         $display("FAIL rdl_data: got db_o=%h oe=%b want c3/1", bus.CPU_DB_O, bus.CPU_DB_OE);
      else n_pass++;
      @(posedge clk); #1 bus.CART_NCS = 1'b1; bus.CPU_RDB = 1'b1;
      n = 0;
      while (bus.BUSY && n < 40) begin @(negedge clk); n++; end
      n_total++;
      if (op_log.size() != exp_q.size())
         $display("FAIL rdl_ops: got %0d ops want %0d", op_log.size(), exp_q.size());
      else n_pass++;
      for (int i = 0; i < exp_q.size() && i < op_log.size(); i++) begin
         n_total++;
         if (op_log[i] !== exp_q[i]) $display("FAIL rdl_op%0d: got %h want %h", i, op_log[i], exp_q[i]);
         else n_pass++;
      end
      n_total++;
      if ({gap_viol, stab_viol} != {32'd0, 32'd0})
         $display("FAIL rdl_protocol: got gap=%0d stab=%0d want 0/0", gap_viol, stab_viol);
      else n_pass++;
   endtask

   task automatic test_ram_write();
      int         r0;
      logic [7:0] rd_exp;
      op_log.delete(); exp_q.delete();
      ack_lat = 2;
      r0 = req_rises;
`ifdef SCV_CART_RAM_EN
      rd_exp = 8'hA5;
      exp_q.push_back({1'b1, 17'h06010, 8'hA5});
`else
      rd_exp = 8'hA0;
`endif
      exp_q.push_back({1'b0, 17'h06010, rd_exp});
      @(posedge clk); #1;
      bus.CPU_A = 16'hE010; bus.CPU_DB_I = 8'hA5; bus.CART_NCS = 1'b0; bus.CPU_WRB = 1'b0;
      repeat (14) @(posedge clk);
      #1 bus.CART_NCS = 1'b1; bus.CPU_WRB = 1'b1;
      repeat (3) @(negedge clk);
`ifndef SCV_CART_RAM_EN
      n_total++;
      if (req_rises != r0) $display("FAIL rom_wr_req: got %0d requests want 0", req_rises - r0);
      else n_pass++;
      n_total++;
      if (cpu_wr_seen !== 1'b0) $display("FAIL rom_wr_state: got cpu_wr_seen=%b want 0", cpu_wr_seen);
      else n_pass++;
`endif
      @(posedge clk); #1;
      bus.CPU_A = 16'hE010; bus.CART_NCS = 1'b0; bus.CPU_RDB = 1'b0;
      repeat (13) @(posedge clk);
      @(negedge clk);
      n_total++;
      if (bus.CPU_DB_O !== rd_exp) $display("FAIL ram_readback: got %h want %h", bus.CPU_DB_O, rd_exp);
      else n_pass++;
      @(posedge clk); #1 bus.CART_NCS = 1'b1; bus.CPU_RDB = 1'b1;
      repeat (3) @(negedge clk);
      n_total++;
      if (op_log.size() != exp_q.size())
         $display("FAIL ram_ops: got %0d ops want %0d", op_log.size(), exp_q.size());
      else n_pass++;
      for (int i = 0; i < exp_q.size() && i < op_log.size(); i++) begin
         n_total++;
         if (op_log[i] !== exp_q[i]) $display("FAIL ram_op%0d: got %h want %h", i, op_log[i], exp_q[i]);
         else n_pass++;
      end
   endtask

   task automatic test_reset_mid();
      int n;
      int r0;
      op_log.delete(); exp_q.delete();
      mem_hold = 1'b1;
      for (int i = 0; i < 2; i++) begin
         @(posedge clk); #1;
         bus.LD_VALID = 1'b1; bus.LD_ADDR = AW'(48 + i); bus.LD_DATA = 8'(8'h5C + i);
      end
      @(posedge clk); #1 bus.LD_VALID = 1'b0;
      n = 0;
      while (!bus.MEM_REQ && n < 10) begin @(negedge clk); n++; end
      n_total++;
      if (n >= 10) $display("FAIL rstm_req_timeout: no request within %0d cycles", n);
      else n_pass++;
      #3 resb = 1'b0;
      #1;
      n_total++;
      if ({bus.MEM_REQ, bus.BUSY, bus.LD_OVF, dbg_state} !== 5'b00000)
         $display("FAIL rstm_async: got req=%b busy=%b ovf=%b state=%0d want 0/0/0/0",
                  bus.MEM_REQ, bus.BUSY, bus.LD_OVF, dbg_state);
      else n_pass++;
      @(posedge clk); #1;
      resb = 1'b1;
      mem_hold = 1'b0;
      r0 = req_rises;
      repeat (10) @(negedge clk);
      n_total++;
      if ((req_rises != r0) || (op_log.size() != 0))
         $display("FAIL rstm_quiet: got %0d requests %0d ops want 0/0", req_rises - r0, op_log.size());
      else n_pass++;
      n_total++;
      if (bus.BUSY !== 1'b0) $display("FAIL rstm_busy: got %b want 0", bus.BUSY);
      else n_pass++;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      bus.CPU_A    = 16'h0000;
      bus.CART_NCS = 1'b1;
      bus.CPU_RDB  = 1'b1;
      bus.CPU_WRB  = 1'b1;
      bus.CPU_DB_I = 8'h00;
      bus.LD_ADDR  = '0;
      bus.LD_DATA  = 8'h00;
      bus.LD_VALID = 1'b0;
      test_reset();
      repeat (2) @(posedge clk);
      test_cpu_read();
      test_ld_writes();
      test_overflow();
      test_read_during_ld();
      test_ram_write();
      test_reset_mid();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
